// File: rtl/riscv_unit_io_pkg.sv
// Shared types and constants for the riscv_unit_io board I/O block:
// UART FSM state types, frame lengths and the active-low seven-segment decode table.
package riscv_unit_io_pkg;

  localparam int unsigned Ps2FrameBits = 11;
  localparam int unsigned UartDataBits = 8;

  typedef enum logic [2:0] {
    StRxIdle,
    StRxStart,
    StRxData,
    StRxParity,
    StRxStop
  } rx_state_e;

  typedef enum logic {
    StTxIdle,
    StTxBusy
  } tx_state_e;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] SegLut [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SegLut[nibble];
  endfunction

endpackage

// File: rtl/riscv_unit_io_ps2_rx.sv
// PS/2 keyboard receiver: synchronizes kclk/kdata, shifts on kclk falling edges and
// emits a one-cycle valid with the byte of every frame with good start, odd parity and stop.
module riscv_unit_io_ps2_rx
  import riscv_unit_io_pkg::*;
#(
  parameter int unsigned PS2_TIMEOUT = 100_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] code_o,
  output logic       valid_o
);

  localparam int unsigned IdleW = $clog2(PS2_TIMEOUT + 1);

  logic [1:0]              kclk_sync_q;
  logic [1:0]              kdata_sync_q;
  logic                    kclk_prev_q;
  logic [Ps2FrameBits-1:0] shift_q, shift_d;
  logic [Ps2FrameBits-1:0] frame;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [IdleW-1:0]        idle_q, idle_d;
  logic [7:0]              code_q, code_d;
  logic                    valid_q, valid_d;
  logic                    fall;

  assign fall  = kclk_prev_q & ~kclk_sync_q[1];
  // Newest bit enters at the top, so after 11 shifts bit 0 holds the start bit
  assign frame = {kdata_sync_q[1], shift_q[Ps2FrameBits-1:1]};

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    idle_d    = idle_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    if (fall) begin
      shift_d = frame;
      idle_d  = '0;
      if (bit_cnt_q == 4'(Ps2FrameBits - 1)) begin
        bit_cnt_d = '0;
        if (!frame[0] && frame[Ps2FrameBits-1] && (^frame[9:1])) begin
          code_d  = frame[8:1];
          valid_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (bit_cnt_q != '0) begin
      if (idle_q >= IdleW'(PS2_TIMEOUT)) begin
        bit_cnt_d = '0;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kclk_sync_q  <= 2'b11;
      kdata_sync_q <= 2'b11;
      kclk_prev_q  <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      idle_q       <= '0;
      code_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      kclk_sync_q  <= {kclk_sync_q[0], kclk_i};
      kdata_sync_q <= {kdata_sync_q[0], kdata_i};
      kclk_prev_q  <= kclk_sync_q[1];
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_q       <= idle_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
    end
  end

  assign code_o  = code_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/riscv_unit_io.sv
// Nexys A7 board I/O: switch-to-LED mirror, PS/2 and UART receivers, hex display scan.
// The UART echo transmitter is built only when RISCV_UNIT_UART_ECHO_EN is defined.
module riscv_unit_io
  import riscv_unit_io_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned PS2_TIMEOUT  = 100_000,
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  input  logic        kclk_i,
  input  logic        kdata_i,
  output logic [6:0]  hex_led_o,
  output logic [7:0]  hex_sel_o,
  input  logic        rx_i,
  output logic        tx_o
);

  localparam int unsigned BIT_CYCLES  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CntW        = $clog2(BIT_CYCLES);

  // Switches to LEDs
  logic [15:0] sw_meta_q, sw_sync_q, led_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
    end else begin
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
      led_q     <= sw_sync_q;
    end
  end

  assign led_o = led_q;

  // PS/2 capture
  logic [7:0] ps2_code;
  logic       ps2_valid;
  logic [7:0] code_last_q, code_prev_q, ps2_cnt_q;

  riscv_unit_io_ps2_rx #(
    .PS2_TIMEOUT(PS2_TIMEOUT)
  ) u_ps2_rx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .kclk_i (kclk_i),
    .kdata_i(kdata_i),
    .code_o (ps2_code),
    .valid_o(ps2_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_last_q <= '0;
      code_prev_q <= '0;
      ps2_cnt_q   <= '0;
    end else if (ps2_valid) begin
      code_prev_q <= code_last_q;
      code_last_q <= ps2_code;
      ps2_cnt_q   <= ps2_cnt_q + 1'b1;
    end
  end

  // UART receiver
  rx_state_e       rx_state_q, rx_state_d;
  logic [1:0]      rx_sync_q;
  logic            rx_prev_q;
  logic            rx_s, rx_fall, rx_tick;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_par_q, rx_par_d;
  logic            rx_wait_q, rx_wait_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      uart_last_q, uart_last_d;

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;
  assign rx_tick = (rx_cnt_q == CntW'(BIT_CYCLES - 1));

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_data_d   = rx_data_q;
    rx_par_d    = rx_par_q;
    rx_wait_d   = rx_wait_q;
    rx_valid_d  = 1'b0;
    uart_last_d = uart_last_q;
    unique case (rx_state_q)
      StRxIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = StRxStart;
      end
      StRxStart: begin
        if (rx_cnt_q == CntW'(HALF_CYCLES - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? StRxIdle : StRxData;
        end
      end
      StRxData: begin
        if (rx_tick) begin
          rx_cnt_d  = '0;
          rx_data_d = {rx_s, rx_data_q[7:1]};
          if (rx_bit_q == 3'(UartDataBits - 1)) rx_state_d = StRxParity;
          else rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      StRxParity: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s;
          rx_state_d = StRxStop;
        end
      end
      StRxStop: begin
        // After a bad frame, hold here until the line is back high
        if (rx_wait_q) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_wait_d  = 1'b0;
            rx_state_d = StRxIdle;
          end
        end else if (rx_tick) begin
          rx_cnt_d = '0;
          if (rx_s && (rx_par_q == ^rx_data_q)) begin
            uart_last_d = rx_data_q;
            rx_valid_d  = 1'b1;
            rx_state_d  = StRxIdle;
          end else if (rx_s) begin
            rx_state_d = StRxIdle;
          end else begin
            rx_wait_d = 1'b1;
          end
        end
      end
      default: rx_state_d = StRxIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q  <= StRxIdle;
      rx_sync_q   <= 2'b11;
      rx_prev_q   <= 1'b1;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_data_q   <= '0;
      rx_par_q    <= 1'b0;
      rx_wait_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      uart_last_q <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_sync_q   <= {rx_sync_q[0], rx_i};
      rx_prev_q   <= rx_s;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_data_q   <= rx_data_d;
      rx_par_q    <= rx_par_d;
      rx_wait_q   <= rx_wait_d;
      rx_valid_q  <= rx_valid_d;
      uart_last_q <= uart_last_d;
    end
  end

`ifdef RISCV_UNIT_UART_ECHO_EN
  // Echo transmitter: start, 8 data, even parity, 2 stop bits; busy drops new bytes
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_left_q, tx_left_d;
  logic [10:0]     tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_left_d  = tx_left_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      StTxIdle: begin
        if (rx_valid_q) begin
          tx_state_d = StTxBusy;
          tx_d       = 1'b0;
          tx_shift_d = {2'b11, ^uart_last_q, uart_last_q};
          tx_left_d  = 4'd11;
          tx_cnt_d   = '0;
        end
      end
      StTxBusy: begin
        if (tx_cnt_q == CntW'(BIT_CYCLES - 1)) begin
          tx_cnt_d = '0;
          if (tx_left_q == '0) begin
            tx_state_d = StTxIdle;
            tx_d       = 1'b1;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[10:1]};
            tx_left_d  = tx_left_q - 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = StTxIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= StTxIdle;
      tx_cnt_q   <= '0;
      tx_left_q  <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_left_q  <= tx_left_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o = tx_q;
`else
  logic unused_rx_valid;
  assign unused_rx_valid = rx_valid_q;
  assign tx_o            = 1'b1;
`endif

  // Display scan
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [2:0]              digit_q;
  logic [3:0]              nibble;
  logic [6:0]              hex_led_q;
  logic [7:0]              hex_sel_q;

  always_comb begin
    nibble = 4'h0;
    unique case (digit_q)
      3'd7: nibble = code_last_q[7:4];
      3'd6: nibble = code_last_q[3:0];
      3'd5: nibble = code_prev_q[7:4];
      3'd4: nibble = code_prev_q[3:0];
      3'd3: nibble = uart_last_q[7:4];
      3'd2: nibble = uart_last_q[3:0];
      3'd1: nibble = ps2_cnt_q[7:4];
      3'd0: nibble = ps2_cnt_q[3:0];
      default: nibble = 4'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refresh_q <= '0;
      digit_q   <= '0;
      hex_led_q <= 7'h7F;
      hex_sel_q <= 8'hFF;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      if (&refresh_q) digit_q <= digit_q + 1'b1;
      hex_sel_q <= ~(8'b1 << digit_q);
      hex_led_q <= seg_decode(nibble);
    end
  end

  assign hex_led_o = hex_led_q;
  assign hex_sel_o = hex_sel_q;

endmodule

// File: tb/tb_riscv_unit_io.sv
// Self-checking bench for riscv_unit_io with a scaled clock/baud, compared against a
// byte-level model of LEDs, captured codes and the display contents.
module tb_riscv_unit_io;

  localparam int ClkHz   = 1_843_200;
  localparam int Baud    = 115_200;
  localparam int BitC    = ClkHz / Baud;
  localparam int HalfC   = BitC / 2;
  localparam int Ps2To   = 200;
  localparam int Ps2Half = 20;
  localparam int RefBits = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [15:0] led;
  logic        kclk;
  logic        kdata;
  logic [6:0]  hex_led;
  logic [7:0]  hex_sel;
  logic        rx;
  logic        tx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rx_start_cyc = 0;

  logic [7:0]  m_last = '0;
  logic [7:0]  m_prev = '0;
  logic [7:0]  m_uart = '0;
  logic [7:0]  m_cnt = '0;
  logic [15:0] m_led = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_unit_io #(
    .CLK_FREQ_HZ (ClkHz),
    .BAUD_RATE   (Baud),
    .PS2_TIMEOUT (Ps2To),
    .REFRESH_BITS(RefBits)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .sw_i     (sw),
    .led_o    (led),
    .kclk_i   (kclk),
    .kdata_i  (kdata),
    .hex_led_o(hex_led),
    .hex_sel_o(hex_sel),
    .rx_i     (rx),
    .tx_o     (tx)
  );

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sw_step(input logic [15:0] v);
    sw = v;
    repeat (2) @(negedge clk);
    chk("led_hold", led, m_led);
    @(negedge clk);
    chk("led_follow", led, v);
    m_led = v;
    repeat (20) @(negedge clk);
  endtask

  task automatic ps2_send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kdata = f[i];
      repeat (Ps2Half) @(negedge clk);
      kclk = 1'b0;
      repeat (Ps2Half) @(negedge clk);
      kclk = 1'b1;
    end
    repeat (Ps2Half) @(negedge clk);
    kdata = 1'b1;
  endtask

  task automatic ps2_frame(input logic [7:0] b);
    ps2_send(b, 1'b0, 11);
    m_prev = m_last;
    m_last = b;
    m_cnt  = m_cnt + 8'd1;
  endtask

  task automatic uart_send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [11:0] f;
    f = {1'b1, ~bad_stop, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 12; i++) begin
      rx = f[i];
      if (i == 0) rx_start_cyc = cyc;
      repeat (BitC) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic watch_tx_idle(input int n, output bit low);
    low = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) low = 1'b1;
    end
  endtask

  task automatic capture_tx(output logic [11:0] f, output int fall_cyc, output bit seen);
    seen = 1'b0;
    f = '0;
    fall_cyc = 0;
    for (int i = 0; i < 20 * BitC && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen = 1'b1;
        fall_cyc = cyc;
      end
    end
    if (seen) begin
      repeat (HalfC) @(negedge clk);
      f[0] = tx;
      for (int i = 1; i < 12; i++) begin
        repeat (BitC) @(negedge clk);
        f[i] = tx;
      end
    end
  endtask

  task automatic uart_frame(input logic [7:0] b);
`ifdef RISCV_UNIT_UART_ECHO_EN
    logic [11:0] f;
    int fc;
    int lat;
    bit seen;
    fork
      uart_send(b, 1'b0, 1'b0);
      capture_tx(f, fc, seen);
    join
    m_uart = b;
    lat = fc - rx_start_cyc;
    chk("echo_seen", seen, 1);
    chk("echo_frame", f, {2'b11, ^b, b, 1'b0});
    // Stop bit sampled ~10.5 bits after the start edge, plus sync and load delay
    chk("echo_latency", (lat >= HalfC + 10 * BitC + 2) && (lat <= HalfC + 10 * BitC + 6), 1);
`else
    bit low;
    fork
      uart_send(b, 1'b0, 1'b0);
      watch_tx_idle(14 * BitC, low);
    join
    m_uart = b;
    chk("tx_const_idle", low, 0);
`endif
  endtask

  task automatic uart_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit low;
    fork
      uart_send(b, bad_par, bad_stop);
      watch_tx_idle(14 * BitC, low);
    join
    chk("bad_frame_no_echo", low, 0);
  endtask

  task automatic check_display(input string tag);
    logic [31:0] v;
    logic [55:0] exp;
    logic [55:0] got;
    logic [7:0]  mask;
    int          badsel;
    v = {m_last, m_prev, m_uart, m_cnt};
    for (int k = 0; k < 8; k++) exp[k*7 +: 7] = seg7(v[k*4 +: 4]);
    got = '0;
    mask = '0;
    badsel = 0;
    for (int i = 0; i < 400 && mask != 8'hFF; i++) begin
      @(negedge clk);
      if ($countones(~hex_sel) != 1) begin
        badsel++;
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (!hex_sel[k]) begin
            got[k*7 +: 7] = hex_led;
            mask[k] = 1'b1;
          end
        end
      end
    end
    chk({tag, "_scan"}, mask, 8'hFF);
    chk({tag, "_onecold"}, badsel, 0);
    chk(tag, got, exp);
  endtask

  initial begin
    bit low;
    rst   = 1'b1;
    sw    = '0;
    kclk  = 1'b1;
    kdata = 1'b1;
    rx    = 1'b1;

    repeat (20) @(negedge clk);
    chk("rst_led", led, 16'h0);
    chk("rst_tx", tx, 1);
    chk("rst_sel", hex_sel, 8'hFF);
    chk("rst_seg", hex_led, 7'h7F);
    rst = 1'b0;
    check_display("disp_reset");

    sw_step(16'hDEAD);
    sw_step(16'h5555);
    sw_step(16'hBEEF);
    sw_step(16'hAAAA);
    for (int i = 0; i < 4; i++) sw_step(16'($urandom));

    ps2_frame(8'h1C);
    ps2_frame(8'hE0);
    ps2_frame(8'hF0);
    ps2_frame(8'h1C);
    ps2_frame(8'h5C);
    check_display("disp_ps2");

    ps2_send(8'h5A, 1'b1, 11);
    check_display("disp_ps2_badpar");

    // A stalled partial frame must be discarded so the next frame aligns
    ps2_send(8'hFF, 1'b0, 4);
    repeat (2 * Ps2To) @(negedge clk);
    ps2_frame(8'h3A);
    check_display("disp_ps2_timeout");

    uart_frame(8'h1C);
    uart_frame(8'h0D);
    uart_frame(8'h0D);
    uart_frame(8'h7F);
    uart_frame(8'h7F);
    check_display("disp_uart");

    uart_bad(8'h42, 1'b1, 1'b0);
    uart_bad(8'h99, 1'b0, 1'b1);
    check_display("disp_uart_bad");

    for (int r = 0; r < 3; r++) begin
      logic [7:0] pb;
      logic [7:0] ub;
      pb = 8'($urandom);
      ub = 8'($urandom);
      fork
        ps2_frame(pb);
        uart_frame(ub);
      join
    end
    check_display("disp_random");

    // Abandon a UART frame part-way through with reset
    rx = 1'b0;
    repeat (4 * BitC) @(negedge clk);
    rx = 1'b1;
    repeat (BitC + HalfC) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    chk("midrx_rst_tx", tx, 1);
    repeat (2) @(negedge clk);
    chk("midrx_rst_sel", hex_sel, 8'hFF);
    rst = 1'b0;
    m_last = '0;
    m_prev = '0;
    m_uart = '0;
    m_cnt  = '0;
    watch_tx_idle(14 * BitC, low);
    chk("midrx_no_echo", low, 0);
    check_display("disp_after_reset");

    ps2_frame(8'h77);
    uart_frame(8'hC3);
    check_display("disp_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_unit_io.md
Name: riscv_unit_io

Overview:
- Self-contained board I/O block for the Nexys A7 (100 MHz), sitting at top level next to the core.
- Mirrors switches onto LEDs and receives PS/2 keyboard scan codes.
- Receives UART bytes and echoes them back.
- Shows recent PS/2 and UART bytes on the 8-digit seven-segment display.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency
- BAUD_RATE, 115200, UART bit rate; BIT_CYCLES = CLK_FREQ_HZ/BAUD_RATE (868)
- PS2_TIMEOUT, 100_000, idle clk cycles mid-frame before the PS/2 bit counter is discarded
- REFRESH_BITS, 17, the display advances one digit every 2^REFRESH_BITS cycles

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- sw_i  in  16  slide switches (asynchronous)
- led_o  out  16  LEDs
- kclk_i  in  1  PS/2 clock (asynchronous)
- kdata_i  in  1  PS/2 data (asynchronous)
- hex_led_o  out  7  segments {g,f,e,d,c,b,a}, active-low
- hex_sel_o  out  8  digit anodes, one-cold, active-low
- rx_i  in  1  UART receive line, idle 1
- tx_o  out  1  UART transmit line, idle 1

Behaviour:
- All asynchronous inputs (sw_i, kclk_i, kdata_i, rx_i) pass through 2-flop synchronizers before use.
- Reset values: led_o=0, tx_o=1, hex_led_o=7'h7F, hex_sel_o=8'hFF. All captured bytes, counters and FSMs clear to 0/idle.
- Switches/LEDs: led_o equals the synchronized sw_i, registered; change is visible 3 cycles after sw_i changes.
- PS/2 receiver:
  - A falling edge of the synchronized kclk shifts in the synchronized kdata.
  - Frame is 11 bits LSB-first: start=0, 8 data bits, odd parity, stop=1.
  - Valid frame: code_prev<=code_last, code_last<=byte, ps2_cnt<=ps2_cnt+1 (8-bit, wraps at 255->0).
  - Bad start, parity or stop: the frame is discarded and no register changes.
  - More than PS2_TIMEOUT cycles without a falling edge mid-frame: bit counter returns to 0.
- UART RX:
  - Frame format: start=0, 8 data LSB-first, even parity (bit = XOR of data), then 1 or more stop bits of 1.
  - Start bit detected on a falling edge of rx; it is re-sampled at BIT_CYCLES/2. If it reads 1 there, the RX FSM returns to IDLE.
  - Subsequent bits are sampled every BIT_CYCLES.
  - FSM states: IDLE, START, DATA, PARITY, STOP.
  - Valid frame: uart_last<=byte and a one-cycle rx_valid pulse.
  - Parity error or stop bit = 0: the frame is discarded and the FSM waits for rx=1 before IDLE.
- UART TX (echo):
  - On rx_valid the byte is loaded if the TX FSM is idle.
  - Sends start, 8 data, even parity, then 2 stop bits, each bit BIT_CYCLES long.
  - First start bit is driven 1 cycle after rx_valid.
  - rx_valid while TX is busy: the byte is dropped and no queue is kept.
- Display:
  - Digit index counter 0..7 (wraps). Digit k is enabled by hex_sel_o[k]=0 and all others are 1.
  - Digits 7:6 = code_last, 5:4 = code_prev, 3:2 = uart_last, 1:0 = ps2_cnt, shown as hex nibbles.
  - Decode (active-low): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.
  - Outputs are registered.
- Reset mid-frame (PS/2, RX or TX): the frame is abandoned, tx_o is 1 on the next cycle and nothing is latched.
- A simultaneous PS/2 and UART completion in the same cycle updates both independently.

Optional Feature:
- Macro RISCV_UNIT_UART_ECHO_EN.
- Defined: UART TX echo as above.
- Undefined: the TX FSM is not built, tx_o is constantly 1, and RX and display behaviour are unchanged.

Decomposition:
- Package riscv_unit_io_pkg holds:
  - the RX/TX state enum types
  - the 16-entry seven-segment decode constant array
  - the default frame-length constants (PS/2 11 bits, UART data 8 bits)
- One sub-module is natural: ps2_rx (synchronizers, edge detect, shift/validate, timeout) with outputs code[7:0] and valid.
- UART RX/TX, switches and display live in the top.

Test Plan:
- Reset held 20 cycles, then released: led_o=0, tx_o=1, hex_sel_o=FF during reset. After release, digits show 00000000 in scan order.
- sw_i 0000->DEAD->5555->BEEF->AAAA, 1000 cycles each: led_o follows each value within 3 cycles.
- PS/2 frames 1C,E0,F0,1C,5C (50 us half-period, odd parity): final digits 7:6="5C", 5:4="1C", 1:0="05". Digit 7 enabled -> hex_led_o=7'h12 ('5').
- PS/2 frame with parity flipped: code_last and ps2_cnt unchanged.
- UART 1C,0D,0D,7F,7F at 115200, even parity, 2 stop bits: digits 3:2 end at "7F". tx_o replays each byte with correct parity, start bit 1 cycle after its rx_valid.
- UART frame with wrong parity, and a reset asserted mid-RX frame: no echo, uart_last unchanged, tx_o stays 1.
